ppi_bus_master: RTL and testbench

- CPU-side initiator for the PPI peripheral bus; the write/encode end of the control-word path.
- Accepts abstract commands over a valid/ready handshake: mode set, port C bit set/reset, port write and port read.
- Encodes the 8-bit control word and drives a timed chip-select/strobe bus cycle into the PPI.
- Keeps a shadow copy of the configured port directions and rejects port writes to input-configured ports.

---
 rtl/ppi_pkg.sv | 40 ++++
 rtl/ppi_cw_encode.sv | 37 +++
 rtl/ppi_bus_master.sv | 207 ++++++++++++++++++++
 tb/tb_ppi_bus_master.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/ppi_pkg.sv
// Shared definitions for the PPI bus master and its control-word encoder.
package ppi_pkg;

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 2;
  localparam int unsigned OP_W   = 2;

  localparam logic [OP_W-1:0] OP_MODE_SET   = 2'b00;
  localparam logic [OP_W-1:0] OP_BSR        = 2'b01;
  localparam logic [OP_W-1:0] OP_WRITE_PORT = 2'b10;
  localparam logic [OP_W-1:0] OP_READ_PORT  = 2'b11;

  localparam logic [ADDR_W-1:0] ADDR_PA   = 2'b00;
  localparam logic [ADDR_W-1:0] ADDR_PB   = 2'b01;
  localparam logic [ADDR_W-1:0] ADDR_PC   = 2'b10;
  localparam logic [ADDR_W-1:0] ADDR_CTRL = 2'b11;

  localparam int unsigned CW_MODE_FLAG = 7;
  localparam int unsigned CW_PA_IN     = 4;
  localparam int unsigned CW_PCU_IN    = 3;
  localparam int unsigned CW_PB_IN     = 1;
  localparam int unsigned CW_PCL_IN    = 0;

  // Shadow / MODE_SET operand layout: {pa_in, pcu_in, pb_in, pcl_in}
  localparam int unsigned SH_PA  = 3;
  localparam int unsigned SH_PCU = 2;
  localparam int unsigned SH_PB  = 1;
  localparam int unsigned SH_PCL = 0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERR    = 3'd5
  } ppi_state_e;

endpackage

// File: rtl/ppi_cw_encode.sv
// Combinational mapping of a command to the bus word and register address.
module ppi_cw_encode
  import ppi_pkg::*;
(
  input  logic [OP_W-1:0]   op_i,
  input  logic [ADDR_W-1:0] port_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] cw_c,
  output logic [ADDR_W-1:0] addr_c
);

  // Group modes are fixed at 0; only the four direction bits are carried.
  always_comb begin
    cw_c   = '0;
    addr_c = ADDR_CTRL;
    unique case (op_i)
      OP_MODE_SET: begin
        cw_c[CW_MODE_FLAG] = 1'b1;
        cw_c[CW_PA_IN]     = data_i[SH_PA];
        cw_c[CW_PCU_IN]    = data_i[SH_PCU];
        cw_c[CW_PB_IN]     = data_i[SH_PB];
        cw_c[CW_PCL_IN]    = data_i[SH_PCL];
      end
      OP_BSR: begin
        cw_c[3:0] = data_i[3:0];
      end
      OP_WRITE_PORT: begin
        cw_c   = data_i;
        addr_c = port_i;
      end
      default: begin
        addr_c = port_i;
      end
    endcase
  end

endmodule

// File: rtl/ppi_bus_master.sv
// CPU-side PPI initiator: encodes commands and runs timed CS/strobe bus cycles.
module ppi_bus_master
  import ppi_pkg::*;
#(
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned PULSE_CYC = 2,
  parameter int unsigned HOLD_CYC  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [ADDR_W-1:0] cmd_port,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_data,
  output logic              ppi_cs_n,
  output logic              ppi_rd_n,
  output logic              ppi_wr_n,
  output logic [ADDR_W-1:0] ppi_a,
  output logic [DATA_W-1:0] ppi_d_out,
  output logic              ppi_d_oe,
  input  logic [DATA_W-1:0] ppi_d_in
);

  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYC - 1);

  ppi_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [3:0]        mode_q, mode_d;
  logic [3:0]        shadow_q, shadow_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  logic              cs_n_q, cs_n_d;
  logic              rd_n_q, rd_n_d;
  logic              wr_n_q, wr_n_d;
  logic [ADDR_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] d_out_q, d_out_d;
  logic              d_oe_q, d_oe_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              cmd_ready_q, cmd_ready_d;

  logic [DATA_W-1:0] enc_cw_c;
  logic [ADDR_W-1:0] enc_addr_c;
  logic              reject_c;
  logic              bus_active_c;

  ppi_cw_encode u_encode (
    .op_i   (cmd_op),
    .port_i (cmd_port),
    .data_i (cmd_data),
    .cw_c   (enc_cw_c),
    .addr_c (enc_addr_c)
  );

  // Commands refused without a bus cycle: bad port, or write to an input port.
  always_comb begin
    reject_c = 1'b0;
    if ((cmd_op == OP_WRITE_PORT || cmd_op == OP_READ_PORT) && cmd_port == ADDR_CTRL) begin
      reject_c = 1'b1;
    end
    if (cmd_op == OP_WRITE_PORT && cmd_port == ADDR_PA && shadow_q[SH_PA]) begin
      reject_c = 1'b1;
    end
    if (cmd_op == OP_WRITE_PORT && cmd_port == ADDR_PB && shadow_q[SH_PB]) begin
      reject_c = 1'b1;
    end
  end

  // Next state, counter, captured command and registered bus outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    mode_d    = mode_q;
    shadow_d  = shadow_q;
    rd_data_d = rd_data_q;
    a_d       = a_q;
    d_out_d   = d_out_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (reject_c) begin
            state_d = ST_ERR;
          end else begin
            state_d = ST_SETUP;
            cnt_d   = SETUP_LOAD;
            op_d    = cmd_op;
            mode_d  = cmd_data[3:0];
            a_d     = enc_addr_c;
            d_out_d = enc_cw_c;
          end
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_STROBE;
          cnt_d   = PULSE_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_STROBE: begin
        if (cnt_q == '0) begin
          if (op_q == OP_READ_PORT) begin
            rd_data_d = ppi_d_in;
          end
          state_d = ST_HOLD;
          cnt_d   = HOLD_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (op_q == OP_MODE_SET) begin
          shadow_d = mode_q;
        end
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs follow the state being entered so they are valid right after the edge.
    bus_active_c = (state_d == ST_SETUP) || (state_d == ST_STROBE) || (state_d == ST_HOLD);
    cs_n_d       = !bus_active_c;
    rd_n_d       = !(state_d == ST_STROBE && op_d == OP_READ_PORT);
    wr_n_d       = !(state_d == ST_STROBE && op_d != OP_READ_PORT);
    d_oe_d       = bus_active_c && (op_d != OP_READ_PORT);
    rsp_valid_d  = (state_d == ST_DONE) || (state_d == ST_ERR);
    rsp_err_d    = (state_d == ST_ERR);
    rsp_data_d   = (state_d == ST_DONE && op_d == OP_READ_PORT) ? rd_data_d : '0;
    cmd_ready_d  = (state_d == ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      op_q        <= OP_MODE_SET;
      mode_q      <= '0;
      shadow_q    <= 4'b1111;
      rd_data_q   <= '0;
      cs_n_q      <= 1'b1;
      rd_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
      a_q         <= '0;
      d_out_q     <= '0;
      d_oe_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
      cmd_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      mode_q      <= mode_d;
      shadow_q    <= shadow_d;
      rd_data_q   <= rd_data_d;
      cs_n_q      <= cs_n_d;
      rd_n_q      <= rd_n_d;
      wr_n_q      <= wr_n_d;
      a_q         <= a_d;
      d_out_q     <= d_out_d;
      d_oe_q      <= d_oe_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_data  = rsp_data_q;
  assign ppi_cs_n  = cs_n_q;
  assign ppi_rd_n  = rd_n_q;
  assign ppi_wr_n  = wr_n_q;
  assign ppi_a     = a_q;
  assign ppi_d_out = d_out_q;
  assign ppi_d_oe  = d_oe_q;

endmodule

// File: tb/tb_ppi_bus_master.sv
// Directed bench for ppi_bus_master with default timing (1/2/1).
module tb_ppi_bus_master;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [1:0] cmd_port;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic       rsp_err;
  logic [7:0] rsp_data;
  logic       ppi_cs_n, ppi_rd_n, ppi_wr_n;
  logic [1:0] ppi_a;
  logic [7:0] ppi_d_out;
  logic       ppi_d_oe;
  logic [7:0] ppi_d_in;

  int n_checks = 0;
  int n_errors = 0;

  // Per-command observations
  int         r_lat, r_vcnt, r_wr_lo, r_rd_lo, r_cs_lo, r_oe_hi, r_viol, r_ready_back;
  logic       r_err;
  logic [7:0] r_data, r_dout;
  logic [1:0] r_a;

  ppi_bus_master dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_port  (cmd_port),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_err   (rsp_err),
    .rsp_data  (rsp_data),
    .ppi_cs_n  (ppi_cs_n),
    .ppi_rd_n  (ppi_rd_n),
    .ppi_wr_n  (ppi_wr_n),
    .ppi_a     (ppi_a),
    .ppi_d_out (ppi_d_out),
    .ppi_d_oe  (ppi_d_oe),
    .ppi_d_in  (ppi_d_in)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one command and watch the eight cycles following the accepting edge.
  task automatic do_cmd(input logic [1:0] op, input logic [1:0] port,
                        input logic [7:0] data, input logic [7:0] din);
    check_eq("ready_before_cmd", 32'(cmd_ready), 32'd1);
    cmd_op = op; cmd_port = port; cmd_data = data; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_op = ~op; cmd_port = ~port; cmd_data = ~data;
    r_lat = 0; r_vcnt = 0; r_wr_lo = 0; r_rd_lo = 0; r_cs_lo = 0; r_oe_hi = 0;
    r_viol = 0; r_ready_back = 0; r_err = 1'b0; r_data = 8'h00; r_dout = 8'h00; r_a = 2'b00;
    for (int i = 1; i <= 8; i++) begin
      if (rsp_valid) begin
        r_vcnt++;
        if (r_lat == 0) begin
          r_lat = i; r_err = rsp_err; r_data = rsp_data;
        end
      end
      if (!ppi_wr_n) r_wr_lo++;
      if (!ppi_rd_n) r_rd_lo++;
      if (ppi_d_oe) r_oe_hi++;
      if (!ppi_cs_n) begin
        if (r_cs_lo == 0) begin
          r_a = ppi_a; r_dout = ppi_d_out;
        end else if (ppi_a !== r_a || ppi_d_out !== r_dout) begin
          r_viol++;
        end
        r_cs_lo++;
      end
      if ((!ppi_rd_n && !ppi_wr_n) || (ppi_cs_n && (!ppi_rd_n || !ppi_wr_n))) r_viol++;
      if (cmd_ready && r_ready_back == 0) r_ready_back = i;
      ppi_d_in = !ppi_rd_n ? din : 8'h00;
      @(posedge clk); #1;
    end
  endtask

  task automatic expect_ok(input string n, input logic [1:0] a, input logic [7:0] dout,
                           input logic chk_dout, input int wr, input int rd, input int oe,
                           input logic [7:0] data);
    check_eq({n, ".lat"}, 32'(r_lat), 32'd5);
    check_eq({n, ".vcnt"}, 32'(r_vcnt), 32'd1);
    check_eq({n, ".err"}, 32'(r_err), 32'd0);
    check_eq({n, ".data"}, 32'(r_data), 32'(data));
    check_eq({n, ".cs_lo"}, 32'(r_cs_lo), 32'd4);
    check_eq({n, ".wr_lo"}, 32'(r_wr_lo), 32'(wr));
    check_eq({n, ".rd_lo"}, 32'(r_rd_lo), 32'(rd));
    check_eq({n, ".oe_hi"}, 32'(r_oe_hi), 32'(oe));
    check_eq({n, ".a"}, 32'(r_a), 32'(a));
    if (chk_dout) check_eq({n, ".dout"}, 32'(r_dout), 32'(dout));
    check_eq({n, ".viol"}, 32'(r_viol), 32'd0);
    check_eq({n, ".ready_back"}, 32'(r_ready_back), 32'd6);
  endtask

  task automatic expect_err(input string n);
    check_eq({n, ".lat"}, 32'(r_lat), 32'd1);
    check_eq({n, ".vcnt"}, 32'(r_vcnt), 32'd1);
    check_eq({n, ".err"}, 32'(r_err), 32'd1);
    check_eq({n, ".data"}, 32'(r_data), 32'd0);
    check_eq({n, ".cs_lo"}, 32'(r_cs_lo), 32'd0);
    check_eq({n, ".strobes"}, 32'(r_wr_lo + r_rd_lo + r_oe_hi), 32'd0);
    check_eq({n, ".ready_back"}, 32'(r_ready_back), 32'd2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    int hit;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_port = 2'b00;
    cmd_data = 8'h00; ppi_d_in = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    // Reset values
    check_eq("rst.cs_n", 32'(ppi_cs_n), 32'd1);
    check_eq("rst.rd_n", 32'(ppi_rd_n), 32'd1);
    check_eq("rst.wr_n", 32'(ppi_wr_n), 32'd1);
    check_eq("rst.a", 32'(ppi_a), 32'd0);
    check_eq("rst.d_out", 32'(ppi_d_out), 32'd0);
    check_eq("rst.d_oe", 32'(ppi_d_oe), 32'd0);
    check_eq("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst.rsp_err", 32'(rsp_err), 32'd0);
    check_eq("rst.rsp_data", 32'(rsp_data), 32'd0);
    check_eq("rst.ready", 32'(cmd_ready), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Port A is input after reset: write refused
    do_cmd(2'b10, 2'b00, 8'h5A, 8'h00);
    expect_err("wrA_in");

    // All ports to output: control word 0x80
    do_cmd(2'b00, 2'b00, 8'h00, 8'h00);
    expect_ok("mode00", 2'b11, 8'h80, 1'b1, 2, 0, 4, 8'h00);

    // Bit 5 set; shadow must stay all-output
    do_cmd(2'b01, 2'b00, 8'h0B, 8'h00);
    expect_ok("bsr0B", 2'b11, 8'h0B, 1'b1, 2, 0, 4, 8'h00);

    // Port A now output: write goes through
    do_cmd(2'b10, 2'b00, 8'h5A, 8'h00);
    expect_ok("wrA_out", 2'b00, 8'h5A, 1'b1, 2, 0, 4, 8'h00);

    // pa_in=1, pcu_in=0, pb_in=1, pcl_in=0 -> 1001_0010
    do_cmd(2'b00, 2'b00, 8'h0A, 8'h00);
    expect_ok("mode0A", 2'b11, 8'h92, 1'b1, 2, 0, 4, 8'h00);

    do_cmd(2'b10, 2'b01, 8'h22, 8'h00);
    expect_err("wrB_in");

    do_cmd(2'b10, 2'b00, 8'h44, 8'h00);
    expect_err("wrA_in2");

    // Port C writes are always allowed
    do_cmd(2'b10, 2'b10, 8'h33, 8'h00);
    expect_ok("wrC", 2'b10, 8'h33, 1'b1, 2, 0, 4, 8'h00);

    // Read port B, bus returns 0xC3 only while RD_n is low
    do_cmd(2'b11, 2'b01, 8'h00, 8'hC3);
    expect_ok("rdB", 2'b01, 8'h00, 1'b0, 0, 2, 0, 8'hC3);

    do_cmd(2'b11, 2'b11, 8'h00, 8'h00);
    expect_err("rd_port3");

    do_cmd(2'b10, 2'b11, 8'h12, 8'h00);
    expect_err("wr_port3");

    // Reset during the write strobe aborts the cycle silently
    cmd_op = 2'b10; cmd_port = 2'b10; cmd_data = 8'h77; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    hit = 0;
    for (int i = 0; i < 6 && hit == 0; i++) begin
      if (!ppi_wr_n) hit = 1;
      else begin
        @(posedge clk); #1;
      end
    end
    check_eq("abort.strobe_seen", 32'(hit), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_eq("abort.wr_n", 32'(ppi_wr_n), 32'd1);
    check_eq("abort.cs_n", 32'(ppi_cs_n), 32'd1);
    check_eq("abort.d_oe", 32'(ppi_d_oe), 32'd0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (rsp_valid) seen++;
      @(posedge clk); #1;
    end
    check_eq("abort.no_rsp", 32'(seen), 32'd0);

    // Shadow back to all-input after reset
    do_cmd(2'b10, 2'b01, 8'h66, 8'h00);
    expect_err("abort.wrB_in");

    // pcu_in=1, pcl_in=1 -> 1000_1001
    do_cmd(2'b00, 2'b00, 8'h05, 8'h00);
    expect_ok("mode05", 2'b11, 8'h89, 1'b1, 2, 0, 4, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
